// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the peripheral-bus initiator.
//   - size codes carried on req_size / size
//   - FSM state encoding
//   - field widths for the bus and the wait-state counter
//   - alignment helper used when requests are accepted
package bus_initiator_pkg;

    localparam int BUS_DATA_W = 64;
    localparam int BUS_ADDR_W = 32;
    localparam int SIZE_W     = 2;
    localparam int WAIT_W     = 4;

    localparam logic [SIZE_W-1:0] SZ_8  = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_16 = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_32 = 2'b10;
    localparam logic [SIZE_W-1:0] SZ_64 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // A request is misaligned when the byte address is not a multiple of
    // the access size; only the low three address bits can matter.
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [SIZE_W-1:0] sz);
        case (sz)
            SZ_8:    return 1'b0;
            SZ_16:   return addr_lo[0];
            SZ_32:   return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Core-request / response handshake plus the strobed peripheral-bus control
// lines of the initiator. The tri-state data lines are not part of this
// bundle; they stay a plain inout net on the initiator.
//   master modport : the initiator (accepts requests, drives bus controls)
//   slave  modport : the core/bus side facing the initiator
interface bus_initiator_if
    import bus_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_W,
    parameter int ADDR_WIDTH = BUS_ADDR_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [SIZE_W-1:0]     req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;

    logic [ADDR_WIDTH-1:0] address;
    logic [SIZE_W-1:0]     size;
    logic                  mem_read;
    logic                  mem_write;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output address, size, mem_read, mem_write
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  address, size, mem_read, mem_write
    );
endinterface

// File: rtl/bus_initiator_size_extend.sv
// Combinational size selector: keeps the low 8/16/32/64 bits of raw and fills
// the upper bits with the selected sign bit (sign_ext=1) or zero.
// Used for load extension and, with sign_ext=0, for store masking.
//   size     in  2           access size code
//   sign_ext in  1           1: replicate top bit of the field, 0: zero fill
//   raw      in  DATA_WIDTH  right-aligned input data
//   ext      out DATA_WIDTH  extended / masked result
module bus_initiator_size_extend
    import bus_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_W
) (
    input  logic [SIZE_W-1:0]     size,
    input  logic                  sign_ext,
    input  logic [DATA_WIDTH-1:0] raw,
    output logic [DATA_WIDTH-1:0] ext
);
    always_comb begin
        ext = raw;
        case (size)
            SZ_8:    ext = {{(DATA_WIDTH-8){sign_ext & raw[7]}},   raw[7:0]};
            SZ_16:   ext = {{(DATA_WIDTH-16){sign_ext & raw[15]}}, raw[15:0]};
            SZ_32:   ext = {{(DATA_WIDTH-32){sign_ext & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/bus_initiator.sv
// Memory-bus initiator: turns single load/store requests from the core into
// strobed transactions on the shared peripheral bus.
//   IDLE -> SETUP (address/size out) -> ACCESS (strobe, WAIT_CYCLES+1 cycles)
//   -> DONE (one-cycle response) -> IDLE.  Misaligned requests jump straight
//   from IDLE to DONE with resp_error and never touch the bus.
// Ports:
//   clk   in     1           system clock, all state on posedge
//   rst   in     1           asynchronous active-high reset
//   bus   master             request/response handshake + bus controls
//   data  inout  DATA_WIDTH  shared tri-state bus data
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int DATA_WIDTH  = BUS_DATA_W,
    parameter int ADDR_WIDTH  = BUS_ADDR_W,
    parameter int WAIT_CYCLES = 0,
    parameter int CHECK_ALIGN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_initiator_if.master       bus,
    inout  wire  [DATA_WIDTH-1:0] data
);
    state_t                state;
    logic                  write_q;
    logic                  signed_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  data_oe;
    logic [WAIT_W-1:0]     wait_cnt;

    logic [ADDR_WIDTH-1:0] req_addr_w;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] store_masked;
    logic [DATA_WIDTH-1:0] load_ext;

    assign req_addr_w = bus.req_addr;
    assign misaligned = (CHECK_ALIGN != 0) && is_misaligned(req_addr_w[2:0], bus.req_size);

    // Store data is masked at accept time so the bus only ever sees the
    // selected field with zero upper bits.
    bus_initiator_size_extend #(.DATA_WIDTH(DATA_WIDTH)) u_store_mask (
        .size     (bus.req_size),
        .sign_ext (1'b0),
        .raw      (bus.req_wdata),
        .ext      (store_masked)
    );

    // Load extension works straight off the bus lines; the size register is
    // only updated for aligned requests, so it always matches a real access.
    bus_initiator_size_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .size     (bus.size),
        .sign_ext (signed_q),
        .raw      (data),
        .ext      (load_ext)
    );

    // The initiator owns the data lines only during a write ACCESS.
    assign data = data_oe ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= '0;
            bus.address    <= '0;
            bus.size       <= SZ_8;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            data_oe        <= 1'b0;
            write_q        <= 1'b0;
            signed_q       <= 1'b0;
            wdata_q        <= '0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                // ---- IDLE: accept a request, or fail it on alignment ----
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        write_q       <= bus.req_write;
                        signed_q      <= bus.req_signed;
                        wdata_q       <= store_masked;
                        bus.req_ready <= 1'b0;
                        if (misaligned) begin
                            state          <= ST_DONE;
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            state       <= ST_SETUP;
                            bus.address <= req_addr_w;
                            bus.size    <= bus.req_size;
                        end
                    end
                end
                // ---- SETUP: address stable one cycle before the strobe ----
                ST_SETUP: begin
                    state         <= ST_ACCESS;
                    wait_cnt      <= WAIT_W'(WAIT_CYCLES);
                    bus.mem_read  <= ~write_q;
                    bus.mem_write <= write_q;
                    data_oe       <= write_q;
                end
                // ---- ACCESS: hold strobe, sample on the final cycle ----
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        state          <= ST_DONE;
                        bus.mem_read   <= 1'b0;
                        bus.mem_write  <= 1'b0;
                        data_oe        <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b0;
                        bus.resp_rdata <= write_q ? '0 : load_ext;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                // ---- DONE: response pulse, then back to IDLE ----
                ST_DONE: begin
                    state          <= ST_IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_error <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
